bellek_yanit_birimi: RTL

Load-response side of the memory interface: records every issued load (type, address byte offset, destination tag) in an in-order pending queue, and accepts the returned data word from memory. For each response it right-aligns the addressed byte/half/word and sign- or zero-extends it per load type. It then presents a registered write-back beat with valid/ready to the register-file writer.

---
 rtl/bellek_yanit_birimi_pkg.sv | 30 +++
 rtl/bellek_yanit_birimi_if.sv | 36 +++
 rtl/bellek_yanit_birimi_kuyruk.sv | 54 +++++
 rtl/bellek_yanit_birimi.sv | 113 +++++++++++
 4 files changed

// File: rtl/bellek_yanit_birimi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bellek_yanit_birimi_pkg : memory uop codes and data-path widths       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package bellek_yanit_birimi_pkg;

   localparam int UOP_BEL_BIT = 4;
   localparam int VERI_BIT    = 32;
   localparam int VERI_BYTE   = VERI_BIT / 8;

   typedef enum logic [UOP_BEL_BIT-1:0] {
      UOP_BEL_NOP = 4'd0,
      UOP_BEL_LB  = 4'd1,
      UOP_BEL_LH  = 4'd2,
      UOP_BEL_LW  = 4'd3,
      UOP_BEL_LBU = 4'd4,
      UOP_BEL_LHU = 4'd5,
      UOP_BEL_SB  = 4'd6,
      UOP_BEL_SH  = 4'd7,
      UOP_BEL_SW  = 4'd8
   } uop_bel_e;

   function automatic logic yukleme_mi(input logic [UOP_BEL_BIT-1:0] uop);
      return (uop == UOP_BEL_LW)  || (uop == UOP_BEL_LH) || (uop == UOP_BEL_LHU) ||
             (uop == UOP_BEL_LB)  || (uop == UOP_BEL_LBU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bellek_yanit_birimi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bellek_yanit_birimi_if : request, memory-response and write-back bus  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface bellek_yanit_birimi_if
   import bellek_yanit_birimi_pkg::*;
#(
   parameter int ETIKET_BIT = 5
);
   logic                   istek_gecerli_i;
   logic                   istek_hazir_o;
   logic [UOP_BEL_BIT-1:0] istek_uop_i;
   logic [1:0]             istek_adres_i;
   logic [ETIKET_BIT-1:0]  istek_etiket_i;
   logic                   bellek_gecerli_i;
   logic [VERI_BIT-1:0]    bellek_veri_i;
   logic                   bellek_hazir_o;
   logic                   gy_gecerli_o;
   logic                   gy_hazir_i;
   logic [VERI_BIT-1:0]    gy_veri_o;
   logic [ETIKET_BIT-1:0]  gy_etiket_o;

   modport slave (
      input  istek_gecerli_i, istek_uop_i, istek_adres_i, istek_etiket_i,
      input  bellek_gecerli_i, bellek_veri_i, gy_hazir_i,
      output istek_hazir_o, bellek_hazir_o, gy_gecerli_o, gy_veri_o, gy_etiket_o
   );

   modport master (
      output istek_gecerli_i, istek_uop_i, istek_adres_i, istek_etiket_i,
      output bellek_gecerli_i, bellek_veri_i, gy_hazir_i,
      input  istek_hazir_o, bellek_hazir_o, gy_gecerli_o, gy_veri_o, gy_etiket_o
   );
endinterface
`default_nettype wire

// File: rtl/bellek_yanit_birimi_kuyruk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | yanit_kuyrugu : generic synchronous FIFO, async active-low reset      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module yanit_kuyrugu #(
   parameter int GENISLIK = 8,
   parameter int DERINLIK = 4
) (
   input  wire logic                clk_i,
   input  wire logic                rstn_i,
   input  wire logic                yaz_i,
   input  wire logic [GENISLIK-1:0] veri_i,
   input  wire logic                oku_i,
   output logic      [GENISLIK-1:0] veri_o,
   output logic                     dolu_o,
   output logic                     bos_o
);
   localparam int ADR_BIT = $clog2(DERINLIK);

   logic [GENISLIK-1:0] r_bellek [DERINLIK];
   logic [ADR_BIT-1:0]  r_yaz_ptr;
   logic [ADR_BIT-1:0]  r_oku_ptr;
   logic [ADR_BIT:0]    r_sayac;
   logic                w_yaz;
   logic                w_oku;

   assign dolu_o = (r_sayac == (ADR_BIT+1)'(DERINLIK));
   assign bos_o  = (r_sayac == '0);
   assign w_yaz  = yaz_i && !dolu_o;
   assign w_oku  = oku_i && !bos_o;
   assign veri_o = r_bellek[r_oku_ptr];

   always_ff @(posedge clk_i) begin
      if (w_yaz) r_bellek[r_yaz_ptr] <= veri_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_yaz_ptr <= '0;
         r_oku_ptr <= '0;
         r_sayac   <= '0;
      end else begin
         if (w_yaz) r_yaz_ptr <= r_yaz_ptr + 1'b1;
         if (w_oku) r_oku_ptr <= r_oku_ptr + 1'b1;
         case ({w_yaz, w_oku})
            2'b10:   r_sayac <= r_sayac + 1'b1;
            2'b01:   r_sayac <= r_sayac - 1'b1;
            default: r_sayac <= r_sayac;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/bellek_yanit_birimi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bellek_yanit_birimi : in-order load response aligner / extender       |
// | optional: BELLEK_HIZALAMA_HATA_EN flags misaligned loads. rev 1.0     |
// +----------------------------------------------------------------------+
module bellek_yanit_birimi
   import bellek_yanit_birimi_pkg::*;
#(
   parameter int KUYRUK_DERINLIK = 4,
   parameter int ETIKET_BIT      = 5
) (
   input  wire logic             clk_i,
   input  wire logic             rstn_i,
   bellek_yanit_birimi_if.slave  bus,
   output logic                  bos_o
`ifdef BELLEK_HIZALAMA_HATA_EN
   ,
   output logic                  hizalama_hata_o
`endif
);
   localparam int KAYIT_BIT = UOP_BEL_BIT + 2 + ETIKET_BIT;

   logic [KAYIT_BIT-1:0]   w_giris;
   logic [KAYIT_BIT-1:0]   w_bas;
   logic [UOP_BEL_BIT-1:0] w_bas_uop;
   logic [1:0]             w_bas_ofs;
   logic [ETIKET_BIT-1:0]  w_bas_etiket;
   logic                   w_dolu;
   logic                   w_bos;
   logic                   w_itme;
   logic                   w_kabul;
   logic [VERI_BIT-1:0]    w_sonuc;
   logic                   r_gy_gecerli;
   logic [VERI_BIT-1:0]    r_gy_veri;
   logic [ETIKET_BIT-1:0]  r_gy_etiket;

   function automatic logic [VERI_BIT-1:0] hizala(input logic [UOP_BEL_BIT-1:0] uop,
                                                  input logic [1:0]             ofs,
                                                  input logic [VERI_BIT-1:0]    veri);
      logic [VERI_BIT-1:0] kay;
      logic [VERI_BIT-1:0] sonuc;
      kay = veri >> {ofs, 3'b000};
      case (uop)
         UOP_BEL_LB:  sonuc = {{(VERI_BIT-8){kay[7]}}, kay[7:0]};
         UOP_BEL_LBU: sonuc = {{(VERI_BIT-8){1'b0}}, kay[7:0]};
         UOP_BEL_LH:  sonuc = {{(VERI_BIT-16){kay[15]}}, kay[15:0]};
         UOP_BEL_LHU: sonuc = {{(VERI_BIT-16){1'b0}}, kay[15:0]};
         default:     sonuc = kay;
      endcase
      return sonuc;
   endfunction

   assign w_giris = {bus.istek_uop_i, bus.istek_adres_i, bus.istek_etiket_i};
   assign {w_bas_uop, w_bas_ofs, w_bas_etiket} = w_bas;

   // Ready signals depend only on registered state and gy_hazir_i.
   assign bus.istek_hazir_o  = !w_dolu;
   assign bus.bellek_hazir_o = !w_bos && (!r_gy_gecerli || bus.gy_hazir_i);
   assign w_itme  = bus.istek_gecerli_i && !w_dolu && yukleme_mi(bus.istek_uop_i);
   assign w_kabul = bus.bellek_gecerli_i && bus.bellek_hazir_o;

   yanit_kuyrugu #(
      .GENISLIK (KAYIT_BIT),
      .DERINLIK (KUYRUK_DERINLIK)
   ) u_kuyruk (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .yaz_i  (w_itme),
      .veri_i (w_giris),
      .oku_i  (w_kabul),
      .veri_o (w_bas),
      .dolu_o (w_dolu),
      .bos_o  (w_bos)
   );

`ifdef BELLEK_HIZALAMA_HATA_EN
   logic w_hizasiz;
   logic r_hata;

   assign w_hizasiz = (((w_bas_uop == UOP_BEL_LH) || (w_bas_uop == UOP_BEL_LHU)) && (w_bas_ofs == 2'd3)) ||
                      ((w_bas_uop == UOP_BEL_LW) && (w_bas_ofs != 2'd0));
   assign w_sonuc   = w_hizasiz ? '0 : hizala(w_bas_uop, w_bas_ofs, bus.bellek_veri_i);
   assign hizalama_hata_o = r_hata;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)                r_hata <= 1'b0;
      else if (w_kabul)           r_hata <= w_hizasiz;
      else if (bus.gy_hazir_i)    r_hata <= 1'b0;
   end
`else
   assign w_sonuc = hizala(w_bas_uop, w_bas_ofs, bus.bellek_veri_i);
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_gy_gecerli <= 1'b0;
         r_gy_veri    <= '0;
         r_gy_etiket  <= '0;
      end else if (w_kabul) begin
         r_gy_gecerli <= 1'b1;
         r_gy_veri    <= w_sonuc;
         r_gy_etiket  <= w_bas_etiket;
      end else if (bus.gy_hazir_i) begin
         r_gy_gecerli <= 1'b0;
      end
   end

   assign bus.gy_gecerli_o = r_gy_gecerli;
   assign bus.gy_veri_o    = r_gy_veri;
   assign bus.gy_etiket_o  = r_gy_etiket;
   assign bos_o            = w_bos && !r_gy_gecerli;
endmodule
`default_nettype wire
